// File: rtl/frame_writer.sv
// frame_writer: rectangle / sprite blitter that writes one pixel per clock into
// the write port of an 8bpp frame buffer. A command is scanned row-major by a
// counter stage (A), registered with its clip flag and address (B) while the
// sprite ROM returns data, and then registered onto the write port.
module frame_writer #(
    parameter int         H_RES       = 640,
    parameter int         V_RES       = 480,
    parameter int         SPR_AW      = 14,
    parameter logic [7:0] TRANSPARENT = 8'hE3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [7:0]        cmd_color,
    input  logic [SPR_AW-1:0] cmd_base,
    output logic [SPR_AW-1:0] spr_addr,
    input  logic [7:0]        spr_data,
    output logic [18:0]       frame_wrAddress,
    output logic [7:0]        frame_input,
    output logic              frame_we,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]  OP_FILL   = 2'b00;
    localparam logic [1:0]  OP_CLEAR  = 2'b01;
    localparam logic [1:0]  OP_SPRITE = 2'b10;
    localparam logic [1:0]  OP_NOP    = 2'b11;
    localparam logic [10:0] H_LIM     = 11'(H_RES);
    localparam logic [10:0] V_LIM     = 11'(V_RES);
    localparam logic [18:0] STRIDE    = 19'(H_RES);

    // Command latch and scan counters
    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [9:0]        x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [7:0]        color_q, color_d;
    logic [9:0]        cx_q, cx_d, cy_q, cy_d;
    logic [SPR_AW-1:0] spr_q, spr_d;
    logic              drain_q, drain_d;

    // Stage B: pixel qualified by clipping, with its address
    logic              b_valid_q, b_valid_d;
    logic              b_sprite_q, b_sprite_d;
    logic [7:0]        b_color_q, b_color_d;
    logic [18:0]       b_addr_q, b_addr_d;

    // Output register
    logic              we_q, we_d;
    logic [18:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    // Stage A arithmetic
    logic [10:0]       px, py;
    logic              clip;
    logic [9:0]        eff_x, eff_y, eff_w, eff_h;

    // Next-state logic for the scan FSM and both pipeline stages
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        spr_d      = spr_q;
        drain_d    = drain_q;

        // Clear screen ignores the supplied geometry and covers the frame.
        eff_x = (cmd_op == OP_CLEAR) ? 10'd0 : cmd_x;
        eff_y = (cmd_op == OP_CLEAR) ? 10'd0 : cmd_y;
        eff_w = (cmd_op == OP_CLEAR) ? 10'(H_RES) : cmd_w;
        eff_h = (cmd_op == OP_CLEAR) ? 10'(V_RES) : cmd_h;

        // 11-bit sums so a rectangle running off the right/bottom edge is
        // clipped rather than wrapping back onto the screen.
        px   = {1'b0, x_q} + {1'b0, cx_q};
        py   = {1'b0, y_q} + {1'b0, cy_q};
        clip = (px >= H_LIM) || (py >= V_LIM);

        b_valid_d  = (state_q == S_RUN) && !clip;
        b_sprite_d = (op_q == OP_SPRITE);
        b_color_d  = color_q;
        // Only unclipped addresses ever reach the port, so modulo-2^19
        // arithmetic here gives the same result as truncating afterwards.
        b_addr_d   = 19'(py) * STRIDE + 19'(px);

        // spr_data now belongs to the pixel held in stage B.
        we_d   = b_valid_q && !(b_sprite_q && (spr_data == TRANSPARENT));
        addr_d = b_valid_q ? b_addr_q : addr_q;
        data_d = b_valid_q ? (b_sprite_q ? spr_data : b_color_q) : data_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    x_d     = eff_x;
                    y_d     = eff_y;
                    w_d     = eff_w;
                    h_d     = eff_h;
                    color_d = cmd_color;
                    cx_d    = 10'd0;
                    cy_d    = 10'd0;
                    spr_d   = cmd_base;
                    if (cmd_op == OP_NOP || eff_w == 10'd0 || eff_h == 10'd0)
                        state_d = S_DONE;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Sprite address advances for clipped pixels too.
                spr_d = spr_q + 1'b1;
                if (cx_q == w_q - 10'd1) begin
                    cx_d = 10'd0;
                    if (cy_q == h_q - 10'd1) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end else begin
                        cy_d = cy_q + 10'd1;
                    end
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last pixel leave stage B and the output.
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
    end

    // All state and registered outputs; reset aborts any command in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_FILL;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            spr_q      <= '0;
            drain_q    <= 1'b0;
            b_valid_q  <= 1'b0;
            b_sprite_q <= 1'b0;
            b_color_q  <= '0;
            b_addr_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            spr_q      <= spr_d;
            drain_q    <= drain_d;
            b_valid_q  <= b_valid_d;
            b_sprite_q <= b_sprite_d;
            b_color_q  <= b_color_d;
            b_addr_q   <= b_addr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready       = ready_q;
    assign spr_addr        = spr_q;
    assign frame_wrAddress = addr_q;
    assign frame_input     = data_q;
    assign frame_we        = we_q;
    assign done            = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: a table of fill/no-op commands issued
// back-to-back, then hand-written sprite, clear-screen and reset sequences.
module tb_frame_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [7:0]  cmd_color;
    logic [13:0] cmd_base;
    logic [13:0] spr_addr;
    logic [7:0]  spr_data;
    logic [18:0] frame_wrAddress;
    logic [7:0]  frame_input;
    logic        frame_we;
    logic        done;

    always #5 Clk = ~Clk;

    frame_writer dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .cmd_w           (cmd_w),
        .cmd_h           (cmd_h),
        .cmd_color       (cmd_color),
        .cmd_base        (cmd_base),
        .spr_addr        (spr_addr),
        .spr_data        (spr_data),
        .frame_wrAddress (frame_wrAddress),
        .frame_input     (frame_input),
        .frame_we        (frame_we),
        .done            (done)
    );

    // Sprite ROM with one cycle of read latency
    logic [7:0] rom [0:16383];
    always @(posedge Clk) spr_data <= rom[spr_addr];

    int n_checks = 0;
    int n_fail   = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_rel[$];
    int done_rel;
    int ready_rel1;
    int ready_issue;
    int ready_done;
    int spr_seen[0:15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one command at the current negedge and record everything up to done.
    // rel = n means cycle T+n, T being the accepting edge.
    task automatic run_cmd(input logic [1:0] op, input int x, input int y,
                           input int w, input int h, input int color, input int base);
        ready_issue = cmd_ready;
        cmd_op    = op;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 8'(color);
        cmd_base  = 14'(base);
        cmd_valid = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        wr_rel.delete();
        done_rel   = -1;
        ready_done = -1;
        for (int rel = 1; rel <= 2000 && done_rel < 0; rel++) begin
            @(negedge Clk);
            if (rel == 1) begin
                cmd_valid  = 1'b0;
                ready_rel1 = int'(cmd_ready);
            end
            if (rel < 16) spr_seen[rel] = int'(spr_addr);
            if (frame_we) begin
                wr_addr.push_back(int'(frame_wrAddress));
                wr_data.push_back(int'(frame_input));
                wr_rel.push_back(rel);
            end
            if (done) begin
                done_rel   = rel;
                ready_done = int'(cmd_ready);
            end
        end
        if (done_rel < 0) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0] op;
        int x, y, w, h, color;
        int exp_ready1, exp_done, exp_nwr;
        int exp_first, exp_first_rel, exp_last, exp_last_rel;
    } vec_t;

    vec_t vecs[7];

    initial begin : main
        int bad;
        int ready_mid;

        for (int i = 0; i < 16384; i++) rom[i] = 8'h00;
        rom[100]   = 8'h05;
        rom[101]   = 8'hE3;
        rom[102]   = 8'h07;
        rom[103]   = 8'hE3;
        rom[16383] = 8'h11;
        rom[0]     = 8'h22;

        //          op     x    y    w  h  color ready1 done nwr first  frel last   lrel
        vecs[0] = '{2'b00, 10,  20,  3, 2, 'h1C, 0,     9,   6,  12810, 3,   13452, 8};
        vecs[1] = '{2'b00, 638, 479, 4, 2, 'h3A, 0,     11,  2,  307198,3,   307199,4};
        vecs[2] = '{2'b00, 5,   5,   0, 4, 'h10, 1,     1,   0,  0,     0,   0,     0};
        vecs[3] = '{2'b11, 5,   5,   5, 5, 'h20, 1,     1,   0,  0,     0,   0,     0};
        vecs[4] = '{2'b00, 0,   0,   1, 1, 'hAA, 0,     4,   1,  0,     3,   0,     3};
        vecs[5] = '{2'b00, 1023,0,   2, 1, 'h55, 0,     5,   0,  0,     0,   0,     0};
        vecs[6] = '{2'b00, 639, 100, 1, 3, 'h81, 0,     6,   3,  64639, 3,   65919, 5};

        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;
        cmd_base  = '0;
        repeat (3) @(negedge Clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_frame_we", int'(frame_we), 0);
        check("rst_done", int'(done), 0);
        check("rst_wraddr", int'(frame_wrAddress), 0);
        check("rst_input", int'(frame_input), 0);
        check("rst_spr_addr", int'(spr_addr), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Table: commands issued back-to-back, each in the previous done cycle
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].op, vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h,
                    vecs[v].color, 0);
            $display("vec %0d op=%0d x=%0d y=%0d w=%0d h=%0d: done@T+%0d, %0d writes",
                     v, vecs[v].op, vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h,
                     done_rel, wr_addr.size());
            check($sformatf("v%0d_ready_issue", v), ready_issue, 1);
            check($sformatf("v%0d_ready_T1", v), ready_rel1, vecs[v].exp_ready1);
            check($sformatf("v%0d_done_cycle", v), done_rel, vecs[v].exp_done);
            check($sformatf("v%0d_ready_done", v), ready_done, 1);
            check($sformatf("v%0d_nwrites", v), wr_addr.size(), vecs[v].exp_nwr);
            if (vecs[v].exp_nwr > 0 && wr_addr.size() > 0) begin
                check($sformatf("v%0d_first_addr", v), wr_addr[0], vecs[v].exp_first);
                check($sformatf("v%0d_first_cycle", v), wr_rel[0], vecs[v].exp_first_rel);
                check($sformatf("v%0d_last_addr", v), wr_addr[$], vecs[v].exp_last);
                check($sformatf("v%0d_last_cycle", v), wr_rel[$], vecs[v].exp_last_rel);
                bad = 0;
                foreach (wr_data[i]) if (wr_data[i] != vecs[v].color) bad++;
                check($sformatf("v%0d_data_bad", v), bad, 0);
            end
        end

        // Sprite copy with transparent pixels skipped
        run_cmd(2'b10, 0, 0, 2, 2, 0, 100);
        $display("sprite 2x2 base=100: done@T+%0d, %0d writes", done_rel, wr_addr.size());
        for (int k = 1; k <= 4; k++)
            check($sformatf("spr_addr_T%0d", k), spr_seen[k], 99 + k);
        check("spr_nwrites", wr_addr.size(), 2);
        check("spr_done_cycle", done_rel, 7);
        if (wr_addr.size() == 2) begin
            check("spr_w0_addr", wr_addr[0], 0);
            check("spr_w0_data", wr_data[0], 'h05);
            check("spr_w0_cycle", wr_rel[0], 3);
            check("spr_w1_addr", wr_addr[1], 640);
            check("spr_w1_data", wr_data[1], 'h07);
            check("spr_w1_cycle", wr_rel[1], 5);
        end

        // Sprite address wraps at the top of the ROM
        run_cmd(2'b10, 0, 0, 2, 1, 0, 16383);
        $display("sprite wrap base=16383: done@T+%0d, %0d writes", done_rel, wr_addr.size());
        check("wrap_spr_T1", spr_seen[1], 16383);
        check("wrap_spr_T2", spr_seen[2], 0);
        check("wrap_done_cycle", done_rel, 5);
        check("wrap_nwrites", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("wrap_w0_data", wr_data[0], 'h11);
            check("wrap_w1_addr", wr_addr[1], 1);
            check("wrap_w1_data", wr_data[1], 'h22);
        end

        // Clear screen: opening stretch of consecutive writes, a stray
        // cmd_valid pulse during RUN, then reset aborts it
        cmd_op    = 2'b01;
        cmd_color = 8'hFF;
        cmd_w     = 10'd5;
        cmd_h     = 10'd5;
        cmd_valid = 1'b1;
        bad       = 0;
        ready_mid = -1;
        for (int rel = 1; rel <= 40; rel++) begin
            @(negedge Clk);
            if (rel == 1) cmd_valid = 1'b0;
            if (rel == 10) begin
                cmd_op    = 2'b00;
                cmd_w     = 10'd1;
                cmd_h     = 10'd1;
                cmd_valid = 1'b1;
            end
            if (rel == 12) cmd_valid = 1'b0;
            if (rel == 20) ready_mid = int'(cmd_ready);
            if (rel >= 3 && !(frame_we === 1'b1 && int'(frame_wrAddress) == rel - 3
                              && frame_input === 8'hFF)) bad++;
            if (rel < 3 && frame_we !== 1'b0) bad++;
        end
        $display("clear screen: %0d bad slots in first 40 cycles", bad);
        check("clr_seq_bad", bad, 0);
        check("clr_ready_in_run", ready_mid, 0);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("clr_rst_we", int'(frame_we), 0);
        check("clr_rst_ready", int'(cmd_ready), 1);
        check("clr_rst_done", int'(done), 0);

        // Reset asserted in cycle T+5 of an 8-pixel fill
        cmd_op    = 2'b00;
        cmd_x     = 10'd0;
        cmd_y     = 10'd0;
        cmd_w     = 10'd8;
        cmd_h     = 10'd1;
        cmd_color = 8'h33;
        cmd_valid = 1'b1;
        bad = 0;
        for (int rel = 1; rel <= 5; rel++) begin
            @(negedge Clk);
            if (rel == 1) cmd_valid = 1'b0;
            if (rel >= 3 && frame_we !== 1'b1) bad++;
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        $display("reset mid-fill: %0d missing writes before reset", bad);
        check("rst_mid_pre_writes", bad, 0);
        check("rst_mid_we", int'(frame_we), 0);
        check("rst_mid_ready", int'(cmd_ready), 1);
        check("rst_mid_done", int'(done), 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (frame_we !== 1'b0 || done !== 1'b0) bad++;
        end
        check("rst_mid_quiet", bad, 0);

        run_cmd(2'b00, 2, 0, 1, 1, 'h44, 0);
        $display("post-reset fill: done@T+%0d, %0d writes", done_rel, wr_addr.size());
        check("post_rst_done", done_rel, 4);
        check("post_rst_nwrites", wr_addr.size(), 1);
        if (wr_addr.size() == 1) begin
            check("post_rst_addr", wr_addr[0], 2);
            check("post_rst_data", wr_data[0], 'h44);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
